gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised memory-mapped GPIO bank on the ARM_64 peripheral bus; next generation of the fixed GPIO register module. Provides WIDTH pins with per-pin direction, atomic set/clear, a synchronised input path, and optional edge-triggered interrupts with mask and write-1-to-clear pending. Sits behind the CPU data-memory bus and shares the bidirectional 64-bit data bus with memory and other peripherals.

## Interface
- BASE_ADDR, 32'h80000000, byte address of register 0; block decodes BASE_ADDR..BASE_ADDR+0x3F
- WIDTH, 32, number of pins, 1..64
- SYNC_STAGES, 2, input synchroniser depth, >= 2

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- data_bi  inout  64  shared data bus; driven only on a read hit, else Z
- address  in  32  byte address
- mem_write  in  1  write strobe, sampled at posedge clock
- mem_read  in  1  read strobe
- size  in  2  access size: 00=8, 01=16, 10=32, 11=64 bits (low bits of register)
- gpio_in  in  WIDTH  asynchronous pin inputs
- gpio_out  out  WIDTH  output register value
- gpio_oe  out  WIDTH  output enable, 1 = pin driven
- irq  out  1  level interrupt, OR of (PEND & MASK)

## Operation
- Register offsets (8-byte aligned): 0x00 IN (RO, synchronised pins), 0x08 OUT (RW), 0x10 DIR (RW, 1=output), 0x18 SET (WO, OUT |= data), 0x20 CLR (WO, OUT &= ~data), 0x28 MASK (RW), 0x30 EDGE (RW, 1=rising, 0=falling), 0x38 PEND (R, W1C).
- Hit: address in range and address[2:0]==0. Misaligned or out-of-range: no write, no bus drive.
- Writes affect only low (8<<size) bits, further limited to WIDTH; other bits keep value. Write data taken from data_bi.
- Reads: data_bi = register zero-extended to 64, then masked to low (8<<size) bits; WO registers read 0.
- mem_read and mem_write both high: write performed, bus not driven.
- gpio_out = OUT, gpio_oe = DIR; pins with DIR=0 still report in IN.
- Edge detect on synchronised input: rising if EDGE=1, falling if EDGE=0; detected edge sets PEND bit regardless of MASK.

## Timing
- Reset (async assert, sync release not required): OUT, DIR, MASK, EDGE, PEND, sync flops = 0; gpio_out=0, gpio_oe=0, irq=0, data_bi=Z.
- Read: combinational; data valid same cycle as mem_read+address, no wait states.
- Write: register updates at posedge where mem_write=1; gpio_out/gpio_oe change after that edge.
- Input latency: pin change visible in IN after SYNC_STAGES edges; PEND set one edge later; irq combinational from PEND & MASK.
- Edge setting a PEND bit in the same cycle as W1C to that bit: set wins.
- Reset mid-access: all state cleared immediately, bus released.

## Configuration
- GPIO_BANK_IRQ_EN defined: MASK, EDGE, PEND, edge detect and irq implemented as above.
- Undefined: offsets 0x28–0x38 read 0 and ignore writes, no edge-detect flops, irq tied 0.

## Structure
- Package gpio_bank_pkg: register offset constants, size encoding constants, function returning byte-lane mask from size.
- Sub-module gpio_sync: per-pin SYNC_STAGES synchroniser plus previous-value flop, outputs sync value and rise/fall pulses.

## Test plan
- Reset then read 0x08, 0x10, 0x38 with size=11 -> all 0; irq=0; data_bi Z when idle.
- Write OUT=64'h30 size=11, DIR=64'h0F -> gpio_out=0x30, gpio_oe=0x0F; SET 64'h01 then CLR 64'h10 -> OUT reads 0x21.
- Write OUT=64'hFFFF size=00 from OUT=0 -> OUT reads 0xFF; read with size=00 of OUT=0x1234 -> 0x34.
- gpio_in[3] 0->1, EDGE[3]=1, MASK[3]=1 -> IN[3]=1 after 2 edges, PEND=0x08 one edge later, irq=1; write PEND 0x08 -> PEND=0, irq=0.
- Rising edge on pin 5 coincident with W1C of bit 5 -> PEND[5] remains 1.
- Access to BASE_ADDR+0x09 or BASE_ADDR+0x40 -> no register change, data_bi stays Z; with GPIO_BANK_IRQ_EN undefined, read 0x28 -> 0, irq=0.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map, access-size encodings and byte-lane helper (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

package gpio_bank_pkg;

  localparam logic [5:0] OFF_IN   = 6'h00;
  localparam logic [5:0] OFF_OUT  = 6'h08;
  localparam logic [5:0] OFF_DIR  = 6'h10;
  localparam logic [5:0] OFF_SET  = 6'h18;
  localparam logic [5:0] OFF_CLR  = 6'h20;
  localparam logic [5:0] OFF_MASK = 6'h28;
  localparam logic [5:0] OFF_EDGE = 6'h30;
  localparam logic [5:0] OFF_PEND = 6'h38;

  localparam logic [31:0] ADDR_SPAN = 32'd64;

  localparam logic [1:0] SIZE_8  = 2'b00;
  localparam logic [1:0] SIZE_16 = 2'b01;
  localparam logic [1:0] SIZE_32 = 2'b10;
  localparam logic [1:0] SIZE_64 = 2'b11;

  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SIZE_8:  m = 64'h0000_0000_0000_00FF;
      SIZE_16: m = 64'h0000_0000_0000_FFFF;
      SIZE_32: m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
// gpio_sync: per-pin input synchroniser with edge pulses (rev 1.0)
// Edge flop and rise/fall pulses exist only when GPIO_BANK_IRQ_EN is defined.
`default_nettype none
`timescale 1ns/1ps

module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign synced = stage[SYNC_STAGES-1];

`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= synced;
  end

  assign rise = synced & ~prev;
  assign fall = ~synced & prev;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank on the shared 64-bit data bus (rev 1.0)
// Define GPIO_BANK_IRQ_EN to build MASK/EDGE/PEND registers and the irq output.
`default_nettype none
`timescale 1ns/1ps

module gpio_bank #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire  [63:0]      data_bi,
  input  logic [31:0]      address,
  input  logic             mem_write,
  input  logic             mem_read,
  input  logic [1:0]       size,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  import gpio_bank_pkg::*;

  // Shifting past bit 63 yields zero, so WIDTH=64 still gives all ones.
  localparam logic [63:0] PIN_MASK = (64'd1 << WIDTH) - 64'd1;

  logic [31:0]      offset;
  logic             hit;
  logic             wr_en;
  logic             rd_en;
  logic [63:0]      wmask_full;
  logic [63:0]      wbits;
  logic [WIDTH-1:0] lane_w;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] rd_reg;
  logic [63:0]      rd_ext;
  logic [63:0]      rdata;
  logic             unused_bits;

  assign offset = address - BASE_ADDR;
  assign hit    = (offset < ADDR_SPAN) && (offset[2:0] == 3'b000);
  assign wr_en  = hit && mem_write;
  // A simultaneous write takes the bus, and reset releases it at once.
  assign rd_en  = hit && mem_read && !mem_write && reset;

  assign wmask_full = lane_mask(size) & PIN_MASK;
  assign wbits      = data_bi & wmask_full;
  assign lane_w     = wmask_full[WIDTH-1:0];
  assign wdata      = wbits[WIDTH-1:0];

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .pins   (gpio_in),
    .synced (synced),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_reg <= '0;
      dir_reg <= '0;
    end else if (wr_en) begin
      case (offset[5:0])
        OFF_OUT: out_reg <= (out_reg & ~lane_w) | wdata;
        OFF_DIR: dir_reg <= (dir_reg & ~lane_w) | wdata;
        OFF_SET: out_reg <= out_reg | wdata;
        OFF_CLR: out_reg <= out_reg & ~wdata;
        default: ;
      endcase
    end
  end

`ifdef GPIO_BANK_IRQ_EN
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_reg;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] pend_clr;

  assign edge_hit = (rise & edge_reg) | (fall & ~edge_reg);
  assign pend_clr = (wr_en && offset[5:0] == OFF_PEND) ? wdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_reg <= '0;
      edge_reg <= '0;
      pend_reg <= '0;
    end else begin
      if (wr_en && offset[5:0] == OFF_MASK) mask_reg <= (mask_reg & ~lane_w) | wdata;
      if (wr_en && offset[5:0] == OFF_EDGE) edge_reg <= (edge_reg & ~lane_w) | wdata;
      // New edges are OR-ed after the clear so a coincident edge survives.
      pend_reg <= (pend_reg & ~pend_clr) | edge_hit;
    end
  end

  assign irq         = |(pend_reg & mask_reg);
  assign unused_bits = ^{wbits, wmask_full};
`else
  assign irq         = 1'b0;
  assign unused_bits = ^{wbits, wmask_full, rise, fall};
`endif

  always_comb begin
    rd_reg = '0;
    case (offset[5:0])
      OFF_IN:   rd_reg = synced;
      OFF_OUT:  rd_reg = out_reg;
      OFF_DIR:  rd_reg = dir_reg;
`ifdef GPIO_BANK_IRQ_EN
      OFF_MASK: rd_reg = mask_reg;
      OFF_EDGE: rd_reg = edge_reg;
      OFF_PEND: rd_reg = pend_reg;
`endif
      default:  rd_reg = '0;
    endcase
  end

  always_comb begin
    rd_ext             = '0;
    rd_ext[WIDTH-1:0]  = rd_reg;
  end

  assign rdata    = rd_ext & lane_mask(size);
  assign data_bi  = rd_en ? rdata : 64'bz;
  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;

endmodule

`default_nettype wire

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank with a register-level reference model (rev 1.0)
`default_nettype none
`timescale 1ns/1ps

module tb_gpio_bank;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          W    = 32;
  localparam logic [63:0] WM   = 64'h0000_0000_FFFF_FFFF;
`ifdef GPIO_BANK_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  wire  [63:0]  data_bi;
  logic [31:0]  address = '0;
  logic         mem_write = 1'b0;
  logic         mem_read = 1'b0;
  logic [1:0]   size = 2'b11;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;
  logic [63:0]  drv = '0;
  logic         drv_en = 1'b0;

  assign data_bi = drv_en ? drv : 64'bz;

  always #5 clock = ~clock;

  gpio_bank #(
    .BASE_ADDR   (BASE),
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_bi   (data_bi),
    .address   (address),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .size      (size),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  // kind: 0 bus value, 1 bus released, 2 gpio_out, 3 gpio_oe, 4 irq
  typedef struct {
    int          kind;
    logic [63:0] exp;
    int          tag;
  } item_t;

  item_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    n_sample   = 0;
  int    tag        = 0;

  function automatic string kname(input int k);
    case (k)
      0:       return "bus_read";
      1:       return "bus_release";
      2:       return "gpio_out";
      3:       return "gpio_oe";
      default: return "irq";
    endcase
  endfunction

  always @(negedge clock) begin
    item_t       it;
    logic [63:0] act;
    bit          ok;
    for (int i = 0; i < n_sample; i++) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_empty tag=%0d", tag);
      end else begin
        it = sb.pop_front();
        case (it.kind)
          0: begin act = data_bi;           ok = (act === it.exp); end
          1: begin act = data_bi;           ok = (data_bi === {64{1'bz}}) || (data_bi === 64'd0); end
          2: begin act = 64'(gpio_out);     ok = (act === it.exp); end
          3: begin act = 64'(gpio_oe);      ok = (act === it.exp); end
          default: begin act = {63'd0, irq}; ok = (act === it.exp); end
        endcase
        if (!ok) begin
          mismatched++;
          if (it.kind == 1)
            $display("FAIL %s tag=%0d actual=%h required=released", kname(it.kind), it.tag, act);
          else
            $display("FAIL %s tag=%0d actual=%h required=%h", kname(it.kind), it.tag, act, it.exp);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] m_out, m_dir, m_mask, m_edge, m_pend, m_pins;

  function automatic logic [63:0] lanes(input logic [1:0] sz);
    if (sz == 2'd3) return {64{1'b1}};
    return (64'd1 << (8 << sz)) - 64'd1;
  endfunction

  function automatic logic [63:0] m_read(input int idx);
    case (idx)
      0: return m_pins;
      1: return m_out;
      2: return m_dir;
      5: return IRQ ? m_mask : 64'd0;
      6: return IRQ ? m_edge : 64'd0;
      7: return IRQ ? m_pend : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return IRQ && ((m_pend & m_mask) != 64'd0);
  endfunction

  task automatic m_reset();
    m_out = 0; m_dir = 0; m_mask = 0; m_edge = 0; m_pend = 0; m_pins = 0;
  endtask

  task automatic m_write(input int idx, input logic [1:0] sz, input logic [63:0] data);
    logic [63:0] m, d;
    m = lanes(sz) & WM;
    d = data & m;
    case (idx)
      1: m_out = (m_out & ~m) | d;
      2: m_dir = (m_dir & ~m) | d;
      3: m_out = m_out | d;
      4: m_out = m_out & ~d;
      5: if (IRQ) m_mask = (m_mask & ~m) | d;
      6: if (IRQ) m_edge = (m_edge & ~m) | d;
      7: if (IRQ) m_pend = m_pend & ~d;
      default: ;
    endcase
  endtask

  task automatic m_pin_change(input logic [63:0] newp);
    logic [63:0] r, f;
    r = newp & ~m_pins;
    f = ~newp & m_pins & WM;
    if (IRQ) m_pend = m_pend | (r & m_edge) | (f & ~m_edge);
    m_pins = newp;
  endtask

  // ---------------- driver ----------------
  task automatic push(input int kind, input logic [63:0] exp);
    item_t it;
    it.kind = kind; it.exp = exp; it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic slot_end();
    @(posedge clock);
    #1;
    n_sample = 0; mem_read = 0; mem_write = 0; drv_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) slot_end();
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] exp, input logic exp_irq);
    tag++;
    address = a; size = sz; mem_read = 1;
    push(0, exp); push(4, {63'd0, exp_irq});
    n_sample = 2;
    slot_end();
  endtask

  task automatic rd_release(input logic [31:0] a, input logic rd_strobe);
    tag++;
    address = a; size = 2'd3; mem_read = rd_strobe;
    push(1, 64'd0);
    n_sample = 1;
    slot_end();
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] data, input logic both);
    tag++;
    address = a; size = sz; drv = data; drv_en = 1; mem_write = 1; mem_read = both;
    slot_end();
  endtask

  task automatic chk_outs(input logic [63:0] eo, input logic [63:0] eoe, input logic ei);
    tag++;
    push(2, eo); push(3, eoe); push(4, {63'd0, ei});
    n_sample = 3;
    slot_end();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout tag=%0d", tag);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, newp;
    logic [31:0] a;
    logic [1:0]  sz;
    int          idx, op;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_outs(0, 0, 0);
    reset = 1;
    rd(BASE + 32'h08, 2'd3, 64'd0, 1'b0);
    rd(BASE + 32'h10, 2'd3, 64'd0, 1'b0);
    rd(BASE + 32'h38, 2'd3, 64'd0, 1'b0);
    rd_release(BASE + 32'h08, 1'b0);

    // OUT/DIR, SET/CLR
    wr(BASE + 32'h08, 2'd3, 64'h30, 0);
    wr(BASE + 32'h10, 2'd3, 64'h0F, 0);
    chk_outs(64'h30, 64'h0F, 0);
    wr(BASE + 32'h18, 2'd3, 64'h01, 0);
    wr(BASE + 32'h20, 2'd3, 64'h10, 0);
    rd(BASE + 32'h08, 2'd3, 64'h21, 1'b0);

    // Size limiting on write and read
    wr(BASE + 32'h08, 2'd3, 64'h0, 0);
    wr(BASE + 32'h08, 2'd0, 64'hFFFF, 0);
    rd(BASE + 32'h08, 2'd3, 64'hFF, 1'b0);
    wr(BASE + 32'h08, 2'd3, 64'h1234, 0);
    rd(BASE + 32'h08, 2'd0, 64'h34, 1'b0);
    rd(BASE + 32'h08, 2'd1, 64'h1234, 1'b0);

    // Rising edge on pin 3: IN after 2 edges, PEND one edge later
    wr(BASE + 32'h30, 2'd3, 64'h08, 0);
    wr(BASE + 32'h28, 2'd3, 64'h08, 0);
    gpio_in = 32'h08;
    rd(BASE, 2'd3, 64'h0, 1'b0);
    rd(BASE, 2'd3, 64'h0, 1'b0);
    rd(BASE, 2'd3, 64'h08, 1'b0);
    rd(BASE + 32'h38, 2'd3, IRQ ? 64'h08 : 64'h0, IRQ);
    wr(BASE + 32'h38, 2'd3, 64'h08, 0);
    rd(BASE + 32'h38, 2'd3, 64'h0, 1'b0);

    // Edge on pin 5 lands on the same edge as its W1C
    wr(BASE + 32'h30, 2'd3, 64'h28, 0);
    gpio_in = 32'h28;
    idle(2);
    wr(BASE + 32'h38, 2'd3, 64'h20, 0);
    rd(BASE + 32'h38, 2'd3, IRQ ? 64'h20 : 64'h0, 1'b0);

    // Misaligned / out-of-range accesses
    wr(BASE + 32'h09, 2'd3, 64'hDEAD, 0);
    wr(BASE + 32'h40, 2'd3, 64'hBEEF, 0);
    rd(BASE + 32'h08, 2'd3, 64'h1234, 1'b0);
    rd_release(BASE + 32'h09, 1'b1);
    rd_release(BASE + 32'h40, 1'b1);
    rd(BASE + 32'h28, 2'd3, IRQ ? 64'h08 : 64'h0, 1'b0);

    // Read and write together: write wins
    wr(BASE + 32'h08, 2'd3, 64'h55, 1);
    rd(BASE + 32'h08, 2'd3, 64'h55, 1'b0);

    // Reset in the middle of a write
    gpio_in = '0;
    tag++;
    address = BASE + 32'h08; size = 2'd3; drv = 64'hAA; drv_en = 1; mem_write = 1;
    #2 reset = 0;
    push(2, 64'd0); push(3, 64'd0); push(4, 64'd0);
    n_sample = 3;
    slot_end();
    reset = 1;
    idle(1);
    rd(BASE + 32'h08, 2'd3, 64'd0, 1'b0);
    rd(BASE + 32'h10, 2'd3, 64'd0, 1'b0);
    rd(BASE + 32'h38, 2'd3, 64'd0, 1'b0);
    m_reset();

    // Randomized traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 3));
      if (op < 4) begin
        d = {$urandom, $urandom};
        a = BASE + 32'(idx * 8);
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 7));
        else m_write(idx, sz, d);
        wr(a, sz, d, ($urandom_range(0, 3) == 0));
        chk_outs(m_out, m_dir, m_irq());
      end else if (op < 8) begin
        rd(BASE + 32'(idx * 8), sz, m_read(idx) & lanes(sz), m_irq());
      end else begin
        newp = {32'd0, $urandom};
        gpio_in = newp[31:0];
        idle(4);
        m_pin_change(newp);
        rd(BASE, 2'd3, m_pins, m_irq());
        rd(BASE + 32'h38, 2'd3, m_read(7), m_irq());
      end
    end

    idle(2);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
